watchdog_timer: RTL
===================

WATCHDOG_TIMER -- requirements
Module: watchdog_timer

Interface
REQ-001 Parameter PULSE_LEN, default 4: number of clk cycles cpu_request is held high (legal range 2..15).
REQ-002 Parameter KICK_KEY, default 32'h5A5A_A5A5: value that must be written to the KICK register to reload the counter.
REQ-003 clk  input  1  system bus clock; all state on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset; the system drives it from ~resetHW, so the block survives CPU resets.
REQ-005 wr_en  input  1  register write strobe, one cycle per write.
REQ-006 addr  input  2  register select: 0 LOAD, 1 VALUE, 2 CTRL, 3 KICK/STATUS.
REQ-007 wr_data  input  32  write data.
REQ-008 rd_data  output  32  combinational read of the register selected by addr.
REQ-009 wdt_irq  output  1  first-timeout interrupt, level, active high.
REQ-010 cpu_request  output  1  CPU reset request to the reset generator, active high.

Function
REQ-011 LOAD (RW, 32 bit) holds the reload value; writing LOAD also loads the counter in the same cycle.
REQ-012 VALUE (RO) returns the current 32-bit down-counter; writes to VALUE are ignored.
REQ-013 CTRL (RW) bit0 EN, bit1 RSTEN; reads return bits [1:0], other bits read 0.
REQ-014 Writing CTRL with wr_data[31]=1 clears the WDRESET flag; the EN and RSTEN fields are still written from wr_data.
REQ-015 KICK write equal to KICK_KEY reloads the counter from LOAD and clears wdt_irq; any other written value is ignored.
REQ-016 Address 3 read returns STATUS {29'b0, WDRESET, IRQ, EN}.
REQ-017 The block has three states: IDLE, COUNT and REQ.
- IDLE → COUNT when EN=1.
- COUNT → IDLE when EN=0; the counter holds its value.
REQ-018 In COUNT, the counter decrements by 1 per cycle while nonzero.
REQ-019 When the counter is 0 in COUNT and IRQ=0: IRQ is set and the counter reloads from LOAD on the next edge.
REQ-020 When the counter is 0 in COUNT with IRQ=1 and RSTEN=1: go to REQ. With RSTEN=0, the counter reloads and IRQ stays set.
REQ-021 In REQ:
- cpu_request = 1 for exactly PULSE_LEN cycles; a 4-bit pulse counter times this.
- Register writes are ignored.
- On exit, WDRESET=1, EN=0, RSTEN=0, IRQ=0, counter reloaded from LOAD, state → IDLE.
REQ-022 cpu_request is a registered output, asserted only in REQ.
REQ-023 wdt_irq equals the IRQ flag.
REQ-024 LOAD=0: a zero count is reached on every COUNT cycle; the first zero sets IRQ, the next zero triggers the request (or another reload if RSTEN=0).
REQ-025 Simultaneous KICK and counter-zero in the same cycle: the KICK wins; the counter reloads and IRQ is cleared.
REQ-026 Simultaneous LOAD write and counter-zero in the same cycle: the counter takes the new LOAD value and IRQ is set per REQ-019/020.
REQ-027 Writing EN=0 while IRQ=1 leaves IRQ set.

Reset
REQ-028 On resetn low, immediately and asynchronously:
- LOAD = 32'hFFFF_FFFF, counter = 32'hFFFF_FFFF.
- EN = 0, RSTEN = 0, IRQ = 0, WDRESET = 0.
- state = IDLE, cpu_request = 0, wdt_irq = 0.
REQ-029 Release of resetn is consumed synchronously; the first decrement occurs no earlier than the second clk edge after EN is written to 1.
REQ-030 Reset asserted mid-REQ terminates the pulse at once (cpu_request = 0) and WDRESET is not set.

Verification
REQ-031 Write LOAD=10, CTRL=3, no kicks → wdt_irq rises 11 cycles after the EN write; cpu_request rises 11 cycles later and stays high 4 cycles; then STATUS reads 3'b100.
REQ-032 LOAD=10, CTRL=3, write KICK_KEY every 8 cycles for 200 cycles → wdt_irq and cpu_request stay 0 throughout.
REQ-033 KICK with 32'h1234_5678 after IRQ is set → IRQ stays 1 and the counter is unchanged; a following KICK_KEY write clears IRQ and VALUE reads 10.
REQ-034 LOAD=5, CTRL=1 (RSTEN=0), run 50 cycles → wdt_irq goes high and stays high, and cpu_request is never asserted.
REQ-035 KICK_KEY written in the exact cycle the counter reaches 0 with IRQ=1 → no REQ entry, and VALUE reloads to LOAD.
REQ-036 Assert resetn low in the 2nd cycle of REQ → cpu_request drops asynchronously, and all registers read their reset values with WDRESET=0.

Source files
------------

// File: rtl/watchdog_timer.sv
// Purpose: bus-programmable watchdog; first timeout raises wdt_irq, second timeout (RSTEN=1) pulses cpu_request.
// Latency: register reads are combinational; writes and counter updates land on the next clk edge.
// Backpressure: none; writes are always accepted except while the reset request pulse is active.
module watchdog_timer #(
  parameter int unsigned PULSE_LEN = 4,
  parameter logic [31:0] KICK_KEY  = 32'h5A5A_A5A5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        wdt_irq,
  output logic        cpu_request
);

  localparam logic [1:0] ADDR_LOAD  = 2'd0;
  localparam logic [1:0] ADDR_VALUE = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;
  localparam logic [1:0] ADDR_KICK  = 2'd3;

  // Last pulse-counter value before leaving REQ; the pulse spans PULSE_LEN edges.
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_REQ   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] load_q, load_d;
  logic [31:0] cnt_q, cnt_d;
  logic        en_q, en_d;
  logic        rsten_q, rsten_d;
  logic        irq_q, irq_d;
  logic        wdreset_q, wdreset_d;
  logic [3:0]  pcnt_q, pcnt_d;
  logic        req_q;

  logic        wr_ok;
  logic        wr_load;
  logic        wr_ctrl;
  logic        kick_ok;

  // The bus is locked out for the whole reset-request pulse.
  assign wr_ok   = wr_en && (state_q != S_REQ);
  assign wr_load = wr_ok && (addr == ADDR_LOAD);
  assign wr_ctrl = wr_ok && (addr == ADDR_CTRL);
  assign kick_ok = wr_ok && (addr == ADDR_KICK) && (wr_data == KICK_KEY);

  // Next-state logic: register writes, countdown, timeout escalation and pulse timing.
  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    rsten_d   = rsten_q;
    irq_d     = irq_q;
    wdreset_d = wdreset_q;
    pcnt_d    = pcnt_q;

    if (wr_load) begin
      load_d = wr_data;
    end
    if (wr_ctrl) begin
      en_d    = wr_data[0];
      rsten_d = wr_data[1];
      if (wr_data[31]) begin
        wdreset_d = 1'b0;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        // Counter holds; the write edge of EN=1 already arms counting.
        if (kick_ok) begin
          cnt_d = load_q;
          irq_d = 1'b0;
        end
        if (wr_load) begin
          cnt_d = wr_data;
        end
        if (en_d) begin
          state_d = S_COUNT;
        end
      end

      S_COUNT: begin
        state_d = en_d ? S_COUNT : S_IDLE;
        if (kick_ok) begin
          // A valid kick beats a coincident zero count.
          cnt_d = load_q;
          irq_d = 1'b0;
        end else if (cnt_q == 32'd0) begin
          cnt_d = load_d;
          if (!irq_q) begin
            irq_d = 1'b1;
          end else if (rsten_q) begin
            state_d = S_REQ;
            pcnt_d  = 4'd0;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
        // A LOAD write always wins the counter value, even at a zero count.
        if (wr_load) begin
          cnt_d = wr_data;
        end
      end

      S_REQ: begin
        if (pcnt_q == PULSE_LAST) begin
          state_d   = S_IDLE;
          wdreset_d = 1'b1;
          en_d      = 1'b0;
          rsten_d   = 1'b0;
          irq_d     = 1'b0;
          cnt_d     = load_q;
          pcnt_d    = 4'd0;
        end else begin
          pcnt_d = pcnt_q + 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset is asynchronous so a CPU-side reset request is cut at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      load_q    <= 32'hFFFF_FFFF;
      cnt_q     <= 32'hFFFF_FFFF;
      en_q      <= 1'b0;
      rsten_q   <= 1'b0;
      irq_q     <= 1'b0;
      wdreset_q <= 1'b0;
      pcnt_q    <= 4'd0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      rsten_q   <= rsten_d;
      irq_q     <= irq_d;
      wdreset_q <= wdreset_d;
      pcnt_q    <= pcnt_d;
      req_q     <= (state_d == S_REQ);
    end
  end

  // Combinational register read mux.
  always_comb begin
    rd_data = 32'd0;
    unique case (addr)
      ADDR_LOAD:  rd_data = load_q;
      ADDR_VALUE: rd_data = cnt_q;
      ADDR_CTRL:  rd_data = {30'd0, rsten_q, en_q};
      ADDR_KICK:  rd_data = {29'd0, wdreset_q, irq_q, en_q};
      default:    rd_data = 32'd0;
    endcase
  end

  assign wdt_irq     = irq_q;
  assign cpu_request = req_q;

endmodule
